// File: rtl/mips32_seq_pkg.sv
// Shared encodings for the MIPS32 multi-cycle sequencer: states, PC source
// selects and trap causes.
package mips32_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } seqState_t;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    localparam logic [1:0] TRAP_NONE  = 2'd0;
    localparam logic [1:0] TRAP_INVOP = 2'd1;
    localparam logic [1:0] TRAP_MEMTO = 2'd2;

    function automatic logic branchTaken(input logic isBeq, input logic isBne,
                                         input logic aluZero);
        return (isBeq && aluZero) || (isBne && !aluZero);
    endfunction

endpackage

// File: rtl/mips32_seq_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags the cycle on which the
// MEM_TIMEOUT-th one occurs; MEM_TIMEOUT of 0 never expires.
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic countEn,
    output logic expire
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] waitCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt <= '0;
        end else if (clear) begin
            waitCnt <= '0;
        end else if (countEn) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // countEn already excludes ready cycles, so ready always wins over expiry
    assign expire = (MEM_TIMEOUT != 0) && countEn && (waitCnt == LIMIT);

endmodule

// File: rtl/mips32_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: drives the shared memory
// handshake, PC/IR load strobes, register writes, traps and the retire counter.
module mips32_mc_sequencer
    import mips32_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isJmp,
    input  logic        isBeq,
    input  logic        isBne,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        rfWriteEnable,
    input  logic        invOpcode,
    input  logic        aluZero,
    input  logic        memReady,
    output logic        memReq,
    output logic        memWe,
    output logic        memAddrSel,
    output logic        irLoad,
    output logic        pcWrite,
    output logic [1:0]  pcSel,
    output logic        rfWe,
    output logic        instRet,
    output logic [31:0] instrCount,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [2:0]  state
);

    seqState_t  stateQ, stateNext;
    logic [1:0] trapCauseQ, trapCauseNext;
    logic       waitClear, waitCountEn, waitExpire;

    assign waitCountEn = ((stateQ == ST_FETCH) || (stateQ == ST_MEM)) && !memReady;
    assign waitClear   = memReady || (stateNext != stateQ);

    seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWaitTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (waitClear),
        .countEn(waitCountEn),
        .expire (waitExpire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= ST_FETCH;
            trapCauseQ <= TRAP_NONE;
        end else begin
            stateQ     <= stateNext;
            trapCauseQ <= trapCauseNext;
        end
    end

    always_comb begin
        stateNext     = stateQ;
        trapCauseNext = trapCauseQ;
        case (stateQ)
            ST_FETCH: begin
                if (memReady) begin
                    stateNext = ST_DECODE;
                end else if (waitExpire) begin
                    stateNext     = ST_TRAP;
                    trapCauseNext = TRAP_MEMTO;
                end
            end
            ST_DECODE: begin
                if (invOpcode) begin
                    stateNext     = ST_TRAP;
                    trapCauseNext = TRAP_INVOP;
                end else begin
                    stateNext = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (isJmp || isBeq || isBne) begin
                    stateNext = ST_FETCH;
                end else if (memRead || memWrite) begin
                    stateNext = ST_MEM;
                end else if (rfWriteEnable) begin
                    stateNext = ST_WB;
                end else begin
                    stateNext = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (memReady) begin
                    stateNext = memWrite ? ST_FETCH : ST_WB;
                end else if (waitExpire) begin
                    stateNext     = ST_TRAP;
                    trapCauseNext = TRAP_MEMTO;
                end
            end
            ST_WB:   stateNext = ST_FETCH;
            ST_TRAP: stateNext = ST_TRAP;
            default: stateNext = ST_TRAP;
        endcase
    end

    always_comb begin
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        irLoad     = 1'b0;
        pcWrite    = 1'b0;
        pcSel      = PCSEL_SEQ;
        rfWe       = 1'b0;
        instRet    = 1'b0;
        case (stateQ)
            ST_FETCH: begin
                memReq = 1'b1;
                if (memReady) begin
                    irLoad  = 1'b1;
                    pcWrite = 1'b1;
                end
            end
            ST_EXEC: begin
                if (isJmp) begin
                    pcWrite = 1'b1;
                    pcSel   = PCSEL_JMP;
                    instRet = 1'b1;
                end else if (isBeq || isBne) begin
                    instRet = 1'b1;
                    if (branchTaken(isBeq, isBne, aluZero)) begin
                        pcWrite = 1'b1;
                        pcSel   = PCSEL_BR;
                    end
                end else if (!(memRead || memWrite) && !rfWriteEnable) begin
                    instRet = 1'b1;
                end
            end
            ST_MEM: begin
                memReq     = 1'b1;
                memAddrSel = 1'b1;
                memWe      = memWrite;
                instRet    = memReady && memWrite;
            end
            ST_WB: begin
                rfWe    = 1'b1;
                instRet = 1'b1;
            end
            default: ;
        endcase
    end

    // Retire counter wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrCount <= '0;
        end else if (instRet) begin
            instrCount <= instrCount + 32'd1;
        end
    end

    assign trap      = (stateQ == ST_TRAP);
    assign trapCause = trapCauseQ;
    assign state     = stateQ;

endmodule

// File: tb/tb_mips32_mc_sequencer.sv
// Randomized instruction stream for mips32_mc_sequencer, checked per cycle against
// a phase-list model of each instruction's expected strobe sequence.
module tb_mips32_mc_sequencer;

    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_JMP = 5, K_NOP = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        isJmp, isBeq, isBne, memRead, memWrite, rfWriteEnable, invOpcode;
    logic        aluZero, memReady;
    logic        memReq, memWe, memAddrSel, irLoad, pcWrite, rfWe, instRet, trap;
    logic [1:0]  pcSel, trapCause;
    logic [2:0]  state;
    logic [31:0] instrCount;

    int passCnt = 0;
    int checkCnt = 0;
    int modelCount = 0;

    mips32_mc_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .isJmp(isJmp), .isBeq(isBeq), .isBne(isBne),
        .memRead(memRead), .memWrite(memWrite), .rfWriteEnable(rfWriteEnable),
        .invOpcode(invOpcode), .aluZero(aluZero), .memReady(memReady),
        .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irLoad(irLoad),
        .pcWrite(pcWrite), .pcSel(pcSel), .rfWe(rfWe), .instRet(instRet),
        .instrCount(instrCount), .trap(trap), .trapCause(trapCause), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt = checkCnt + 1;
        assert (obs === exp) begin
            passCnt = passCnt + 1;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {memReq, memWe, memAddrSel, irLoad, pcWrite, pcSel[1:0], rfWe, instRet, trap, state[2:0]}
    function automatic logic [12:0] ev(input bit req, input bit we, input bit addr, input bit ir,
                                       input bit pcw, input logic [1:0] sel, input bit rf,
                                       input bit ret, input bit tr, input logic [2:0] st);
        return {req, we, addr, ir, pcw, sel, rf, ret, tr, st};
    endfunction

    function automatic logic [12:0] obsVec();
        return {memReq, memWe, memAddrSel, irLoad, pcWrite, pcSel, rfWe, instRet, trap, state};
    endfunction

    // Compare at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [12:0] exp);
        logic [12:0] mask;
        mask = '1;
        if (!exp[12]) mask[11:10] = 2'b00;
        if (!exp[8])  mask[7:6]   = 2'b00;
        @(negedge clk);
        check(tag, 32'(obsVec() & mask), 32'(exp & mask));
        @(posedge clk);
        #1;
    endtask

    task automatic randDecode();
        isJmp = 1'($urandom); isBeq = 1'($urandom); isBne = 1'($urandom);
        memRead = 1'($urandom); memWrite = 1'($urandom);
        rfWriteEnable = 1'($urandom); invOpcode = 1'($urandom);
        aluZero = 1'($urandom);
    endtask

    task automatic setDecode(input int kind);
        isJmp = 0; isBeq = 0; isBne = 0; memRead = 0; memWrite = 0;
        rfWriteEnable = 0; invOpcode = 0;
        case (kind)
            K_ALU: rfWriteEnable = 1;
            K_LW:  begin memRead = 1; rfWriteEnable = 1; end
            K_SW:  memWrite = 1;
            K_BEQ: isBeq = 1;
            K_BNE: isBne = 1;
            K_JMP: isJmp = 1;
            default: ;
        endcase
    endtask

    // fw / mw = not-ready cycles before ready in FETCH / MEM
    task automatic runInstr(input int kind, input int fw, input int mw, input bit z);
        string nm;
        bit taken;
        nm = $sformatf("k%0d", kind);
        for (int i = 0; i <= fw; i++) begin
            randDecode();
            memReady = (i == fw);
            step({nm, ".fetch"}, ev(1, 0, 0, i == fw, i == fw, 2'd0, 0, 0, 0, 3'd0));
        end
        setDecode(kind);
        memReady = 1'($urandom);
        aluZero = 1'($urandom);
        step({nm, ".decode"}, ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd1));
        aluZero = z;
        memReady = 1'($urandom);
        taken = (kind == K_BEQ && z) || (kind == K_BNE && !z);
        case (kind)
            K_JMP:        step({nm, ".exec"}, ev(0, 0, 0, 0, 1, 2'd2, 0, 1, 0, 3'd2));
            K_BEQ, K_BNE: step({nm, ".exec"}, ev(0, 0, 0, 0, taken, 2'd1, 0, 1, 0, 3'd2));
            K_NOP:        step({nm, ".exec"}, ev(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 3'd2));
            default:      step({nm, ".exec"}, ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd2));
        endcase
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                memReady = (i == mw);
                aluZero = 1'($urandom);
                step({nm, ".mem"}, ev(1, kind == K_SW, 1, 0, 0, 2'd0, 0,
                                      (kind == K_SW) && (i == mw), 0, 3'd3));
            end
        end
        if (kind == K_LW || kind == K_ALU) begin
            memReady = 1'($urandom);
            step({nm, ".wb"}, ev(0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 3'd4));
        end
        modelCount = modelCount + 1;
        check({nm, ".count"}, instrCount, 32'(modelCount));
        check({nm, ".refetch"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst_n = 0;
        setDecode(K_NOP);
        aluZero = 0;
        memReady = 0;
        #1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.memReq", 32'(memReq), 32'd1);
        check("rst.count", instrCount, 32'd0);
        check("rst.trap", 32'({trap, trapCause}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;

        runInstr(K_ALU, 0, 0, 0);
        runInstr(K_LW, 0, 3, 0);
        runInstr(K_BEQ, 0, 0, 1);
        runInstr(K_BEQ, 0, 0, 0);
        runInstr(K_ALU, 3, 0, 0);
        runInstr(K_SW, 1, 3, 0);
        for (int n = 0; n < 40; n++) begin
            runInstr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom));
        end

        // Reset in the middle of a store's memory phase
        randDecode();
        memReady = 1;
        step("rsw.fetch", ev(1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 3'd0));
        setDecode(K_SW);
        memReady = 0;
        step("rsw.decode", ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd1));
        step("rsw.exec", ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd2));
        step("rsw.mem", ev(1, 1, 1, 0, 0, 2'd0, 0, 0, 0, 3'd3));
        rst_n = 0;
        #1;
        check("rsw.memWe", 32'(memWe), 32'd0);
        check("rsw.state", 32'(state), 32'd0);
        check("rsw.count", instrCount, 32'd0);
        check("rsw.strobes", 32'({pcWrite, rfWe, instRet}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        modelCount = 0;
        runInstr(K_ALU, 0, 0, 0);

        // Fetch never ready: trap after exactly four not-ready cycles
        setDecode(K_NOP);
        memReady = 0;
        for (int i = 0; i < 4; i++) begin
            step("to.fetch", ev(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd0));
        end
        check("to.state", 32'(state), 32'd5);
        check("to.cause", 32'(trapCause), 32'd2);
        check("to.trap", 32'(trap), 32'd1);
        rst_n = 0;
        #1;
        check("to.rst", 32'({trap, trapCause, state}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        modelCount = 0;

        // Invalid opcode traps from DECODE and stays put
        runInstr(K_NOP, 0, 0, 0);
        randDecode();
        memReady = 1;
        step("inv.fetch", ev(1, 0, 0, 1, 1, 2'd0, 0, 0, 0, 3'd0));
        setDecode(K_ALU);
        invOpcode = 1;
        step("inv.decode", ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 3'd1));
        check("inv.cause", 32'(trapCause), 32'd1);
        for (int i = 0; i < 20; i++) begin
            randDecode();
            memReady = 1'($urandom);
            step("inv.hold", ev(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 3'd5));
        end
        check("inv.causeHeld", 32'(trapCause), 32'd1);
        check("inv.count", instrCount, 32'(modelCount));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/mips32_mc_sequencer.md
# mips32_mc_sequencer

Multi-cycle sequencer for the MIPS32 SoC core. It steps every instruction through FETCH, DECODE, EXEC, MEM and WB using the decode signals produced by the control unit. It owns the single shared memory port's request/ready handshake, plus PC and IR load timing. It traps on invalid opcodes or a stalled memory bus, and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum consecutive not-ready cycles on a memory request; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- isJmp, isBeq, isBne  in  1 each  decoded control-flow class
- memRead, memWrite, rfWriteEnable, invOpcode  in  1 each  decoded instruction class
- aluZero  in  1  ALU result == 0 (valid in EXEC)
- memReady  in  1  memory accepts/completes the current request this cycle
- memReq  out  1  memory request active
- memWe  out  1  request is a write
- memAddrSel  out  1  0 = PC, 1 = ALU result
- irLoad  out  1  latch fetched word into IR
- pcWrite  out  1  update PC
- pcSel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- rfWe  out  1  register-file write strobe
- instRet  out  1  one-cycle pulse per retired instruction
- instrCount  out  32  retired-instruction counter
- trap  out  1  sticky fault flag
- trapCause  out  2  0 = none, 1 = invalid opcode, 2 = memory timeout
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. The state register is clocked; all other outputs except the counters are combinational from state and inputs.
- FETCH: memReq=1, memAddrSel=0, memWe=0.
  - While memReady=0, remain in FETCH.
  - When memReady=1: irLoad=1, pcWrite=1, pcSel=0, then go to DECODE.
- DECODE: no strobes.
  - If invOpcode=1, go to TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC:
  - isJmp: pcWrite=1, pcSel=2, instRet, go to FETCH.
  - Branch taken when (isBeq & aluZero) | (isBne & ~aluZero): pcWrite=1, pcSel=1. Taken or not, instRet and go to FETCH.
  - memRead or memWrite: go to MEM.
  - rfWriteEnable: go to WB.
  - Anything else: instRet, go to FETCH.
- MEM: memReq=1, memAddrSel=1, memWe=memWrite.
  - Hold until memReady=1.
  - On ready, a load goes to WB; a store asserts instRet and goes to FETCH.
- WB: rfWe=1, instRet, go to FETCH.
- TRAP: absorbing; every strobe is 0, trap=1, and trapCause holds its value. Only reset exits TRAP.
- Wait timer: waitCnt, width $clog2(MEM_TIMEOUT+1).
  - Increments each FETCH/MEM cycle with memReady=0.
  - Clears on memReady=1 and on any state change.
  - If waitCnt == MEM_TIMEOUT-1 and memReady=0 (and MEM_TIMEOUT≠0), go to TRAP with cause 2. This traps after exactly MEM_TIMEOUT non-ready cycles.
- instrCount increments on every instRet cycle and wraps 0xFFFFFFFF→0.

## Timing
- Reset values: state=FETCH, waitCnt=0, instrCount=0, trap=0, trapCause=0. Because memReq is decoded from state, memReq=1 during reset and in the first cycle after release.
- Cycle counts with memReady=1 immediately, measured from FETCH entry to the next FETCH entry:
  - branch/jump: 3
  - ALU/LUI: 4
  - store: 4
  - load: 5
- Each not-ready cycle adds one.
- memReady sampled outside FETCH/MEM is ignored.
- In FETCH, PC+4 is written on the same edge that IR loads. Branch targets are computed from the updated PC.
- Reset asserted mid-instruction aborts it immediately:
  - no pending pcWrite/rfWe completes;
  - instrCount clears.
- Timeout and ready in the same cycle: ready wins.

## Structure
- Shared package mips32_seq_pkg holds:
  - state encodings;
  - pcSel codes (PCSEL_SEQ/BR/JMP);
  - trap cause codes (TRAP_NONE/INVOP/MEMTO).
- Sub-module seq_wait_timer holds waitCnt and the timeout compare. Its interface: clear, count enable, expire output.

## Test plan
- ADDI with memReady tied 1 → FETCH, DECODE, EXEC, WB over 4 cycles. Exactly one rfWe pulse; instrCount=1.
- LW with memReady low for 3 cycles in MEM → 8 cycles total. memAddrSel=1 and memWe=0 in MEM; rfWe asserts in the cycle after ready.
- BEQ, once with aluZero=1 and once with aluZero=0 → pcSel=1 with pcWrite=1 in EXEC, versus no pcWrite. Both take 3 cycles and both pulse instRet.
- invOpcode=1 in DECODE → state=5, trap=1, trapCause=1. All strobes stay 0 for the next 20 cycles.
- MEM_TIMEOUT=4, memReady held 0 in FETCH → TRAP with cause 2 after exactly 4 cycles. A second run with ready on the 4th cycle must not trap.
- rst_n pulsed low during MEM of an SW → memWe drops asynchronously, state=FETCH, instrCount=0. Next fetch proceeds normally.
